// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, load/store requester and memory-array signals
// that meet at mem_port_arbiter.
//
// Handshake semantics (both requesters):
//   - A requester raises *_req with its command fields stable and holds them
//     until it sees *_gnt. *_gnt is a one-cycle pulse: the command is
//     accepted at the rising edge that ends the cycle in which *_gnt is 1.
//   - The requester must drop *_req (or present a new command) after that edge.
//   - *_rvalid is a one-cycle pulse with no backpressure. The requester must
//     take *_rdata (and d_err) in that cycle.
//   - The memory returns mem_rdata the cycle after mem_en & !mem_we.
//
// Modports:
//   master : requesters and memory model side
//            (drive requests and mem_rdata; observe grants, responses and
//            memory commands)
//   slave  : the arbiter
// dbg_state exposes the arbiter FSM state for checkers.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_type;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  // memory array
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  // debug
  logic [1:0]        dbg_state;

  modport master (
    output if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_state
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, word-wide memory between instruction fetch and
// load/store.
//   - Data requests have priority over fetch.
//   - After MAX_D_STREAK consecutive data grants with fetch waiting, fetch is
//     forced to win the next arbitration.
//   - Byte and halfword loads are extracted and sign- or zero-extended.
//   - Byte and halfword stores run as a read-modify-write:
//     read the word, then write it back with one lane replaced.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : mem_port_arbiter_if.slave (requesters, memory and dbg_state)
//
// Parameters:
//   MAX_D_STREAK : 1..15, data-grant streak limit while fetch is pending
//   ADDR_W       : byte address width
//
// Optional feature (macro MEM_PORT_ARBITER_MISALIGN_CHECK_EN):
//   When defined, misaligned data accesses are flagged:
//     - a half access with addr[0] set
//     - a word access with addr[1:0] != 0
//   Such an access is granted, but no memory access is made.
//   The cycle after the grant returns d_rvalid with d_err=1 and d_rdata=0.
//   When undefined, d_err is 0 and the low address bits are simply ignored.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t            state_q, state_d;
  logic [3:0]        streak_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [2:0]        lat_type_q;
  logic [15:0]       lat_wdata_q;
  logic              lat_id_q;   // 1 = data requester, 0 = fetch
  logic              lat_err_q;  // latched misaligned flag

  logic        d_mis;
  logic        d_win;
  logic        f_win;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;
  logic [31:0] st_word;

`ifdef MEM_PORT_ARBITER_MISALIGN_CHECK_EN
  assign d_mis = ((bus.d_type[1:0] == 2'b01) && bus.d_addr[0]) ||
                 (bus.d_type[1] && (bus.d_addr[1:0] != 2'b00));
`else
  assign d_mis = 1'b0;
`endif

  // Arbitration only happens in IDLE and never during reset.
  assign d_win = (state_q == IDLE) && !rst && bus.d_req &&
                 !(bus.if_req && (streak_q == STREAK_MAX));
  assign f_win = (state_q == IDLE) && !rst && !d_win && bus.if_req;

  assign bus.dbg_state = state_q;
  assign bus.if_rdata  = bus.mem_rdata;

  // Load formatting and store-lane merge, both from the latched request.
  always_comb begin
    lane_b = bus.mem_rdata[7:0];
    case (lat_addr_q[1:0])
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      2'd3:    lane_b = bus.mem_rdata[31:24];
      default: lane_b = bus.mem_rdata[7:0];
    endcase
    lane_h = lat_addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    case (lat_type_q[1:0])
      2'b00:   ld_data = {{24{lane_b[7] & ~lat_type_q[2]}}, lane_b};
      2'b01:   ld_data = {{16{lane_h[15] & ~lat_type_q[2]}}, lane_h};
      default: ld_data = bus.mem_rdata;
    endcase

    st_word = bus.mem_rdata;
    if (lat_type_q[1:0] == 2'b00) begin
      case (lat_addr_q[1:0])
        2'd1:    st_word[15:8]  = lat_wdata_q[7:0];
        2'd2:    st_word[23:16] = lat_wdata_q[7:0];
        2'd3:    st_word[31:24] = lat_wdata_q[7:0];
        default: st_word[7:0]   = lat_wdata_q[7:0];
      endcase
    end else if (lat_addr_q[1]) begin
      st_word[31:16] = lat_wdata_q;
    end else begin
      st_word[15:0] = lat_wdata_q;
    end
  end

  // Next state and outputs
  always_comb begin
    state_d       = state_q;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_err     = 1'b0;
    bus.d_rdata   = lat_err_q ? 32'h0 : ld_data;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {lat_addr_q[ADDR_W-1:2], 2'b00};
    bus.mem_wdata = st_word;

    case (state_q)
      IDLE: begin
        if (d_win) begin
          bus.d_gnt     = 1'b1;
          bus.mem_addr  = {bus.d_addr[ADDR_W-1:2], 2'b00};
          bus.mem_wdata = bus.d_wdata;
          if (d_mis) begin
            state_d = RD_WAIT;  // error response, no memory access
          end else if (!bus.d_we) begin
            bus.mem_en = 1'b1;
            state_d    = RD_WAIT;
          end else if (bus.d_type[1]) begin
            bus.mem_en = 1'b1;  // full-word store completes now
            bus.mem_we = 1'b1;
          end else begin
            bus.mem_en = 1'b1;  // read the target word for the merge
            state_d    = RMW_WR;
          end
        end else if (f_win) begin
          bus.if_gnt   = 1'b1;
          bus.mem_en   = 1'b1;
          bus.mem_addr = {bus.if_addr[ADDR_W-1:2], 2'b00};
          state_d      = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_id_q) begin
          bus.d_rvalid = 1'b1;
          bus.d_err    = lat_err_q;
        end else begin
          bus.if_rvalid = 1'b1;
        end
        state_d = IDLE;
      end
      RMW_WR: begin
        bus.mem_en = 1'b1;
        bus.mem_we = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset abandons any operation in flight and masks every strobe.
    if (rst) begin
      state_d       = IDLE;
      bus.if_gnt    = 1'b0;
      bus.d_gnt     = 1'b0;
      bus.if_rvalid = 1'b0;
      bus.d_rvalid  = 1'b0;
      bus.d_err     = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      lat_addr_q  <= '0;
      lat_type_q  <= 3'd0;
      lat_wdata_q <= 16'd0;
      lat_id_q    <= 1'b0;
      lat_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (d_win) begin
        lat_addr_q  <= bus.d_addr;
        lat_type_q  <= bus.d_type;
        lat_wdata_q <= bus.d_wdata[15:0];
        lat_id_q    <= 1'b1;
        lat_err_q   <= d_mis;
        // The streak counts only data grants that made fetch wait.
        if (bus.if_req) begin
          streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
        end else begin
          streak_q <= 4'd0;
        end
      end else if (f_win) begin
        lat_addr_q <= bus.if_addr;
        lat_id_q   <= 1'b0;
        lat_err_q  <= 1'b0;
        streak_q   <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a behavioural word memory.
//   - A table of data-side transactions is driven through the DUT.
//   - Response expectations are queued at grant time and compared when
//     rvalid appears.
//   - Hand-written sequences cover:
//       fetch
//       fetch starvation
//       reset during the read-modify-write write cycle
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(32)) bus();

  mem_port_arbiter #(
    .MAX_D_STREAK(4),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  logic [31:0] rdata_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            rdata_q <= mem[bus.mem_addr[9:2]];
    end
  end
  assign bus.mem_rdata = rdata_q;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] d_exp_q[$];   // {d_err, d_rdata}
  logic [31:0] if_exp_q[$];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (bus.d_rvalid) begin
      if (d_exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d_unexpected_rvalid: got rdata %h err %b, expected no response",
                 bus.d_rdata, bus.d_err);
      end else begin
        e = d_exp_q.pop_front();
        check("d_rsp", {bus.d_err, bus.d_rdata}, e);
      end
    end
    if (bus.if_rvalid) begin
      if (if_exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL if_unexpected_rvalid: got rdata %h, expected no response", bus.if_rdata);
      end else begin
        e = {1'b0, if_exp_q.pop_front()};
        check("if_rsp", {1'b0, bus.if_rdata}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_data(input string name, input logic we, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp, input logic exp_err, input logic exp_en);
    logic got;
    got = 1'b0;
    @(negedge clk);
    bus.d_we    = we;
    bus.d_type  = typ;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.d_gnt) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_gnt"}, {32'h0, got}, 33'h1);
    if (got) begin
      check({name, "_mem_en"}, {32'h0, bus.mem_en}, {32'h0, exp_en});
      check({name, "_mem_we"}, {32'h0, bus.mem_we}, {32'h0, we && typ[1] && exp_en});
      if (exp_en) check({name, "_mem_addr"}, {1'b0, bus.mem_addr}, {1'b0, addr & 32'hFFFF_FFFC});
      if (we && typ[1] && exp_en) check({name, "_mem_wdata"}, {1'b0, bus.mem_wdata}, {1'b0, wdata});
      if (!we || !exp_en) d_exp_q.push_back({exp_err, exp});
    end
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
    if (got && we && !typ[1] && exp_en) begin
      @(negedge clk);
      check({name, "_rmw_cmd"}, {31'h0, bus.mem_en, bus.mem_we}, 33'h3);
      check({name, "_rmw_addr"}, {1'b0, bus.mem_addr}, {1'b0, addr & 32'hFFFF_FFFC});
      check({name, "_rmw_wdata"}, {1'b0, bus.mem_wdata}, {1'b0, exp});
    end
  endtask

  task automatic do_fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic got;
    got = 1'b0;
    @(negedge clk);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.if_gnt) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_gnt"}, {32'h0, got}, 33'h1);
    if (got) begin
      check({name, "_mem_cmd"}, {31'h0, bus.mem_en, bus.mem_we}, 33'h2);
      check({name, "_mem_addr"}, {1'b0, bus.mem_addr}, {1'b0, addr & 32'hFFFF_FFFC});
      if_exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    check({name, "_rvalid_n1"}, {32'h0, bus.if_rvalid}, {32'h0, got});
    check({name, "_no_gnt_rd_wait"}, {31'h0, bus.if_gnt, bus.d_gnt}, 33'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // load result, or merged word for sub-word stores
    logic        err;
    logic        en;
  } vec_t;

  vec_t vecs[20];

  // ---------------- main sequence ----------------
  initial begin
    logic got_f;
    logic done;
    int   n_d;

    rst         = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_type  = 3'b010;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;

    vecs[0]  = '{1'b1, 3'b010, 32'h200, 32'h80FF7F01, 32'h0,        1'b0, 1'b1};
    vecs[1]  = '{1'b0, 3'b000, 32'h202, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 3'b100, 32'h202, 32'h0,        32'h000000FF, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 3'b000, 32'h200, 32'h0,        32'h00000001, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'b000, 32'h201, 32'h0,        32'h0000007F, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 3'b000, 32'h203, 32'h0,        32'hFFFFFF80, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 3'b001, 32'h200, 32'h0,        32'h00007F01, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 3'b001, 32'h202, 32'h0,        32'hFFFF80FF, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 3'b101, 32'h202, 32'h0,        32'h000080FF, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 3'b010, 32'h200, 32'h0,        32'h80FF7F01, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'hABCD3344, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 3'b010, 32'h300, 32'h0,        32'hABCD3344, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 3'b000, 32'h301, 32'h0000005A, 32'hABCD5A44, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 3'b110, 32'h300, 32'h0,        32'hABCD5A44, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1};
`ifdef MEM_PORT_ARBITER_MISALIGN_CHECK_EN
    vecs[16] = '{1'b0, 3'b010, 32'h402, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[17] = '{1'b0, 3'b001, 32'h401, 32'h0,        32'h0,        1'b1, 1'b0};
`else
    vecs[16] = '{1'b0, 3'b010, 32'h402, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 3'b001, 32'h401, 32'h0,        32'hFFFFF00D, 1'b0, 1'b1};
`endif
    vecs[18] = '{1'b1, 3'b000, 32'h403, 32'h00000077, 32'h77FEF00D, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 3'b100, 32'h403, 32'h0,        32'h00000077, 1'b0, 1'b1};

    // Reset holds every strobe low even with both requests active.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_strobes",
          {26'h0, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.d_err,
           bus.mem_en, bus.mem_we}, 33'h0);
    check("reset_state", {31'h0, bus.dbg_state}, 33'h0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch: place an instruction and read it, including an unaligned address.
    do_data("init_100", 1'b1, 3'b010, 32'h100, 32'h00000013, 32'h0, 1'b0, 1'b1);
    do_fetch("fetch_100", 32'h100, 32'h00000013);
    do_fetch("fetch_102", 32'h102, 32'h00000013);

    for (int i = 0; i < 20; i++) begin
      do_data($sformatf("v%0d", i), vecs[i].we, vecs[i].typ, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp, vecs[i].err, vecs[i].en);
    end

    // Starvation guard: both held, expect 4 data grants, a fetch, then data again.
    @(negedge clk);
    bus.d_we    = 1'b0;
    bus.d_type  = 3'b010;
    bus.d_addr  = 32'h200;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.if_req  = 1'b1;
    n_d   = 0;
    got_f = 1'b0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus.d_gnt) begin
        if (got_f) done = 1'b1;
        else       n_d++;
        d_exp_q.push_back({1'b0, 32'h80FF7F01});
      end
      if (bus.if_gnt) begin
        if (!got_f) check("starve_data_grants", 33'(n_d), 33'd4);
        got_f = 1'b1;
        if_exp_q.push_back(32'h00000013);
      end
      @(negedge clk);
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    check("starve_fetch_seen", {32'h0, got_f}, 33'h1);
    check("starve_data_after_fetch", {32'h0, done}, 33'h1);

    // Reset during the RMW write cycle: no write, everything idle afterwards.
    repeat (2) @(negedge clk);
    bus.d_we    = 1'b1;
    bus.d_type  = 3'b001;
    bus.d_addr  = 32'h400;
    bus.d_wdata = 32'h00001234;
    bus.d_req   = 1'b1;
    #1;
    check("rst_rmw_gnt", {32'h0, bus.d_gnt}, 33'h1);
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("rst_rmw_no_write", {31'h0, bus.mem_en, bus.mem_we}, 33'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rmw_idle_outputs",
          {26'h0, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.d_err,
           bus.mem_en, bus.mem_we}, 33'h0);
    check("rst_rmw_state", {31'h0, bus.dbg_state}, 33'h0);
    do_data("rst_rmw_readback", 1'b0, 3'b010, 32'h400, 32'h0, 32'h77FEF00D, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    check("d_queue_empty", 33'(d_exp_q.size()), 33'd0);
    check("if_queue_empty", 33'(if_exp_q.size()), 33'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule
